// File: rtl/cp0_timer.sv
// Coprocessor-0 for the pipelined MIPS core: status/cause/EPC state, interrupt and
// exception arbitration, and a free-running Count/Compare timer.
module cp0_timer #(
    parameter int          HW_INT_W = 5,
    parameter logic [31:0] PRID     = 32'h0000_0001,
    parameter logic [31:0] CMP_RST  = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          A1,
    input  logic [4:0]          A2,
    input  logic [31:0]         Din,
    input  logic                WE,
    input  logic [31:0]         PC,
    input  logic [31:0]         VAddr,
    input  logic [4:0]          ExcCodeIn,
    input  logic                BDin,
    input  logic [HW_INT_W-1:0] HWInt,
    input  logic                EXLClr,
    output logic                Req,
    output logic [31:0]         EPCout,
    output logic [31:0]         Dout,
    output logic                TimerIrq
);

    localparam logic [4:0] A_BADV  = 5'd8;
    localparam logic [4:0] A_COUNT = 5'd9;
    localparam logic [4:0] A_CMP   = 5'd11;
    localparam logic [4:0] A_SR    = 5'd12;
    localparam logic [4:0] A_CAUSE = 5'd13;
    localparam logic [4:0] A_EPC   = 5'd14;
    localparam logic [4:0] A_PRID  = 5'd15;

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [4:0]  ip_q;
    logic [4:0]  exc_q;
    logic [31:0] epc_q;
    logic [31:0] badv_q;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [31:0] compare_q;
    logic        ti_q;
    logic        ti_d;

    logic [4:0]  hw_ext_s;
    logic [5:0]  pend_s;
    logic        int_req_s;
    logic        exc_req_s;
    logic        wr_s;
    logic        wr_count_s;
    logic        wr_cmp_s;
    logic        wr_sr_s;
    logic        wr_epc_s;
    logic        addr_exc_s;

    // External lines beyond HW_INT_W are tied low so unused IP bits read 0.
    assign hw_ext_s   = 5'(HWInt);
    assign pend_s     = {ti_q, hw_ext_s};
    assign int_req_s  = (|(pend_s & im_q)) & ie_q & ~exl_q;
    assign exc_req_s  = (ExcCodeIn != 5'd0) & ~exl_q;
    assign Req        = int_req_s | exc_req_s;
    assign EPCout     = Req ? (BDin ? (PC - 32'd4) : PC) : epc_q;
    assign TimerIrq   = ti_q;

    // A taken request squashes the concurrent mtc0.
    assign wr_s       = WE & ~Req;
    assign wr_count_s = wr_s & (A2 == A_COUNT);
    assign wr_cmp_s   = wr_s & (A2 == A_CMP);
    assign wr_sr_s    = wr_s & (A2 == A_SR);
    assign wr_epc_s   = wr_s & (A2 == A_EPC);
    assign addr_exc_s = ~int_req_s & ((ExcCodeIn == 5'd4) | (ExcCodeIn == 5'd5));

    // Timer next state: load beats increment, Compare write beats a match.
    always_comb begin
        count_d = count_q + 32'd1;
        ti_d    = ti_q;
        if (wr_count_s) begin
            count_d = Din;
        end else begin
            count_d = count_q + 32'd1;
        end
        if (wr_cmp_s) begin
            ti_d = 1'b0;
        end else if (count_d == compare_q) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end
    end

    // mfc0 read mux.
    always_comb begin
        Dout = 32'd0;
        case (A1)
            A_BADV:  Dout = badv_q;
            A_COUNT: Dout = count_q;
            A_CMP:   Dout = compare_q;
            A_SR:    Dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
            A_CAUSE: Dout = {bd_q, 15'd0, ti_q, ip_q, 3'd0, exc_q, 2'd0};
            A_EPC:   Dout = epc_q;
            A_PRID:  Dout = PRID;
            default: Dout = 32'd0;
        endcase
    end

    // Architectural state update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 5'd0;
            exc_q     <= 5'd0;
            epc_q     <= 32'd0;
            badv_q    <= 32'd0;
            count_q   <= 32'd0;
            compare_q <= CMP_RST;
            ti_q      <= 1'b0;
        end else begin
            ip_q    <= hw_ext_s;
            count_q <= count_d;
            ti_q    <= ti_d;
            if (wr_cmp_s) begin
                compare_q <= Din;
            end
            if (Req) begin
                exl_q <= 1'b1;
                bd_q  <= BDin;
                epc_q <= EPCout;
                exc_q <= int_req_s ? 5'd0 : ExcCodeIn;
                if (addr_exc_s) begin
                    badv_q <= VAddr;
                end
            end else begin
                if (wr_sr_s) begin
                    im_q  <= Din[15:10];
                    exl_q <= Din[1];
                    ie_q  <= Din[0];
                end else if (EXLClr) begin
                    exl_q <= 1'b0;
                end
                if (wr_epc_s) begin
                    epc_q <= Din;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_timer.sv
// Randomized and directed bench for cp0_timer: a driver pushes reference-model
// expectations into a scoreboard queue, a monitor pops and compares each cycle.
module tb_cp0_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [4:0]   A1, A2, ExcCodeIn;
    logic [31:0]  Din, PC, VAddr;
    logic         WE, BDin, EXLClr;
    logic [W-1:0] HWInt;
    logic         Req, TimerIrq;
    logic [31:0]  EPCout, Dout;

    cp0_timer #(.HW_INT_W(W)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .WE(WE),
        .PC(PC), .VAddr(VAddr), .ExcCodeIn(ExcCodeIn), .BDin(BDin),
        .HWInt(HWInt), .EXLClr(EXLClr), .Req(Req), .EPCout(EPCout),
        .Dout(Dout), .TimerIrq(TimerIrq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0]  m_sr, m_count, m_compare, m_epc, m_bad;
    logic         m_ti, m_bd;
    logic [4:0]   m_exc;
    logic [W-1:0] m_ip;

    typedef struct {
        logic        req;
        logic [31:0] epc;
        logic [31:0] dout;
        logic        ti;
        logic [4:0]  a1;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    logic [4:0] amap [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

    function automatic logic [5:0] m_pend();
        logic [5:0] p = 6'd0;
        for (int i = 0; i < W; i++) p[i] = HWInt[i];
        p[5] = m_ti;
        return p;
    endfunction

    function automatic logic m_int();
        return ((m_pend() & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_epcout();
        if (!m_req()) return m_epc;
        return BDin ? PC - 32'd4 : PC;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_sr;
            5'd13:   return ({31'd0, m_bd} << 31) | ({31'd0, m_ti} << 15) |
                            ({{(32-W){1'b0}}, m_ip} << 10) | ({27'd0, m_exc} << 2);
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_0001;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] pick();
        int k = $urandom_range(0, 7);
        if (k == 7) return 5'($urandom);
        return amap[k];
    endfunction

    task automatic model_reset();
        m_sr = 32'd0; m_count = 32'd0; m_compare = 32'hFFFF_FFFF; m_epc = 32'd0;
        m_bad = 32'd0; m_ti = 1'b0; m_bd = 1'b0; m_exc = 5'd0; m_ip = '0;
    endtask

    task automatic model_clock();
        logic r, ir, wr;
        logic [31:0] eo, nc;
        r = m_req(); ir = m_int(); eo = m_epcout();
        wr = WE && !r;
        nc = (wr && A2 == 5'd9) ? Din : m_count + 32'd1;
        if (wr && A2 == 5'd11) m_ti = 1'b0;
        else if (nc == m_compare) m_ti = 1'b1;
        if (wr && A2 == 5'd11) m_compare = Din;
        m_count = nc;
        if (r) begin
            m_sr[1] = 1'b1; m_bd = BDin; m_epc = eo;
            m_exc = ir ? 5'd0 : ExcCodeIn;
            if (!ir && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5)) m_bad = VAddr;
        end else begin
            if (wr && A2 == 5'd12) m_sr = Din & 32'h0000_FC03;
            else if (EXLClr) m_sr[1] = 1'b0;
            if (wr && A2 == 5'd14) m_epc = Din;
        end
        m_ip = HWInt;
    endtask

    task automatic push_exp();
        exp_t e;
        e.req = m_req(); e.epc = m_epcout(); e.dout = m_read(A1); e.ti = m_ti; e.a1 = A1;
        sb.push_back(e);
    endtask

    task automatic idle();
        WE = 1'b0; A2 = 5'd0; Din = 32'd0; ExcCodeIn = 5'd0; BDin = 1'b0;
        HWInt = '0; EXLClr = 1'b0;
    endtask

    // Called at a falling edge with inputs already set; returns at the next one.
    task automatic step();
        push_exp();
        @(posedge clk);
        if (!reset) model_clock();
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        idle();
        #1 reset = 1'b1;
        model_reset();
        push_exp();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("Req", {31'd0, Req}, {31'd0, e.req});
                chk("EPCout", EPCout, e.epc);
                chk($sformatf("Dout[a=%0d]", e.a1), Dout, e.dout);
                chk("TimerIrq", {31'd0, TimerIrq}, {31'd0, e.ti});
            end
        end
    end

    initial begin
        idle(); A1 = 5'd9; PC = 32'h4000; VAddr = 32'd0;
        model_reset();
        @(negedge clk);
        rst_pulse();
        // Timer interrupt through IM[15]
        WE = 1'b1; A2 = 5'd9;  Din = 32'd0;      step();
        A2 = 5'd11; Din = 32'd10;                step();
        A2 = 5'd12; Din = 32'h0000_8001;         step();
        idle(); repeat (12) step();
        A1 = 5'd13; step(); A1 = 5'd14; step(); A1 = 5'd12; step();
        // HW interrupt taken in a delay slot right after eret
        WE = 1'b1; A2 = 5'd12; Din = 32'h0000_0403; step();
        idle(); HWInt = 4'b0001; BDin = 1'b1; PC = 32'h3010; EXLClr = 1'b1; step();
        EXLClr = 1'b0; A1 = 5'd13; step();
        step();
        // Address-error exception with a squashed mtc0 EPC
        idle(); EXLClr = 1'b1; step();
        idle(); ExcCodeIn = 5'd4; VAddr = 32'h1003; WE = 1'b1; A2 = 5'd14;
        Din = 32'hDEAD_BEEF; PC = 32'h5000; A1 = 5'd8; step();
        idle(); step(); A1 = 5'd13; step(); A1 = 5'd14; step();
        // Compare write coincident with a match, then Count wrap
        WE = 1'b1; A2 = 5'd11; Din = 32'd30; step();
        A2 = 5'd9; Din = 32'd28; step();
        idle(); A1 = 5'd9; step();
        WE = 1'b1; A2 = 5'd11; Din = 32'd50; step();
        idle(); step();
        WE = 1'b1; A2 = 5'd9; Din = 32'hFFFF_FFFF; step();
        idle(); step(); step();
        // eret together with a new exception: EXL stays set
        EXLClr = 1'b1; step();
        idle(); ExcCodeIn = 5'd5; EXLClr = 1'b1; step();
        idle(); A1 = 5'd12; step();
        // Asynchronous reset in the middle of a cycle
        A1 = 5'd9; step(); step();
        rst_pulse();
        step();
        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            A1 = pick(); A2 = pick(); WE = ($urandom_range(0, 2) == 0);
            Din = $urandom;
            if (A2 == 5'd11) Din = m_count + 32'($urandom_range(0, 12));
            else if (A2 == 5'd9 && $urandom_range(0, 1) == 1) Din = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            ExcCodeIn = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            BDin = 1'($urandom_range(0, 1));
            PC = $urandom; VAddr = $urandom;
            HWInt = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            EXLClr = ($urandom_range(0, 3) == 0) && !(WE && A2 == 5'd12);
            if ($urandom_range(0, 199) == 0) rst_pulse();
            else step();
        end
        idle();
        #20;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
